// File: rtl/acc_wbuf_pkg.sv
// Shared types and width helpers for the ping-pong accumulate write-back buffer.
package acc_wbuf_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_STORE = 2'd2
  } drain_state_t;

  // Row-count width: must hold the value DEPTH itself.
  function automatic int rt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/acc_wbuf_bank.sv
// One bank of row storage: single write port, asynchronous read port, sync clear.
module acc_wbuf_bank
  import acc_wbuf_pkg::*;
#(
  parameter  int WIDTH = 68,
  parameter  int DEPTH = 4,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/acc_wbuf_pingpong.sv
// Ping-pong write-back buffer: fills one bank from the output stage while the
// other drains to output memory under WB_READY back-pressure.
module acc_wbuf_pingpong
  import acc_wbuf_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int ADDR_W = 4,
  parameter  int DEPTH  = 4,
  localparam int RT_W   = rt_w(DEPTH),
  localparam int IDX_W  = idx_w(DEPTH)
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CLR_DP,
  input  logic              ACC_ctrl,
  input  logic [RT_W-1:0]   ROW_TOTAL,
  input  logic [ADDR_W-1:0] ODST_om,
  input  logic              OMWrite_om,
  input  logic [DATA_W-1:0] DACC,
  input  logic              WB_READY,
  output logic              LOAD_DONE,
  output logic              STORE_DONE,
  output logic [ADDR_W-1:0] ODST_wb,
  output logic              EN_wb,
  output logic [DATA_W-1:0] WData_wb,
  output logic              OVF,
  output logic              BUSY
);

  localparam int              ROW_W    = ADDR_W + DATA_W;
  localparam logic [RT_W-1:0] DEPTH_RT = RT_W'(DEPTH);
  localparam logic [RT_W-1:0] ONE_RT   = RT_W'(1);

  drain_state_t    r_state, w_state_n;
  logic            r_wr_bank, r_rd_bank, r_active;
  logic [1:0]      r_full, w_full_n;
  logic [RT_W-1:0] r_rt_q, r_wcnt, r_rcnt, w_wcnt_n;
  logic [ROW_W-1:0] w_rdata [2];
  logic [ROW_W-1:0] w_rd_row;
  logic [1:0]      w_we;
  logic            w_store_acc, w_release, w_writable, w_accept, w_drop, w_fill_last;

  assign w_store_acc = (r_state == S_STORE) && WB_READY;
  assign w_release   = w_store_acc && (r_rcnt == r_rt_q - ONE_RT);
  // A bank whose last row is leaving this cycle may take a new row in the same cycle.
  assign w_writable  = !r_full[r_wr_bank] || (w_release && (r_rd_bank == r_wr_bank));
  assign w_accept    = OMWrite_om && r_active && w_writable;
  assign w_drop      = OMWrite_om && r_active && !w_writable;
  assign w_fill_last = w_accept && (r_wcnt == r_rt_q - ONE_RT);
  assign w_we[0]     = w_accept && !r_wr_bank;
  assign w_we[1]     = w_accept && r_wr_bank;
  assign w_rd_row    = w_rdata[r_rd_bank];

  acc_wbuf_bank #(.WIDTH(ROW_W), .DEPTH(DEPTH)) u_bank0 (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_clr   (CLR_DP),
    .i_we    (w_we[0]),
    .i_waddr (r_wcnt[IDX_W-1:0]),
    .i_wdata ({ODST_om, DACC}),
    .i_raddr (r_rcnt[IDX_W-1:0]),
    .o_rdata (w_rdata[0])
  );

  acc_wbuf_bank #(.WIDTH(ROW_W), .DEPTH(DEPTH)) u_bank1 (
    .i_clk   (CLK),
    .i_rst_n (RSTN),
    .i_clr   (CLR_DP),
    .i_we    (w_we[1]),
    .i_waddr (r_wcnt[IDX_W-1:0]),
    .i_wdata ({ODST_om, DACC}),
    .i_raddr (r_rcnt[IDX_W-1:0]),
    .o_rdata (w_rdata[1])
  );

  always_comb begin
    w_full_n = r_full;
    if (w_release)   w_full_n[r_rd_bank] = 1'b0;
    if (w_fill_last) w_full_n[r_wr_bank] = 1'b1;
  end

  always_comb begin
    w_wcnt_n = r_wcnt;
    if (w_fill_last)   w_wcnt_n = '0;
    else if (w_accept) w_wcnt_n = r_wcnt + ONE_RT;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (r_full[r_rd_bank]) w_state_n = S_ARM;
      S_ARM:   w_state_n = S_STORE;
      S_STORE: if (w_release) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= S_IDLE;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_active   <= 1'b0;
      r_full     <= '0;
      r_rt_q     <= DEPTH_RT;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      LOAD_DONE  <= 1'b0;
      STORE_DONE <= 1'b0;
      OVF        <= 1'b0;
      EN_wb      <= 1'b0;
      ODST_wb    <= '0;
      WData_wb   <= '0;
    end else if (CLR_DP) begin
      r_state    <= S_IDLE;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_active   <= 1'b0;
      r_full     <= '0;
      r_rt_q     <= DEPTH_RT;
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      LOAD_DONE  <= 1'b0;
      STORE_DONE <= 1'b0;
      OVF        <= 1'b0;
      EN_wb      <= 1'b0;
      ODST_wb    <= '0;
      WData_wb   <= '0;
    end else begin
      r_state    <= w_state_n;
      r_full     <= w_full_n;
      r_wcnt     <= w_wcnt_n;
      LOAD_DONE  <= w_fill_last;
      STORE_DONE <= w_release;
      OVF        <= w_drop;
      EN_wb      <= w_store_acc;
      if (w_fill_last) r_wr_bank <= ~r_wr_bank;
      if (w_release)   r_rd_bank <= ~r_rd_bank;
      if (ACC_ctrl)
        r_rt_q <= ((ROW_TOTAL == '0) || (ROW_TOTAL > DEPTH_RT)) ? DEPTH_RT : ROW_TOTAL;
      // Tile start wins over the end-of-tile release.
      if (ACC_ctrl)
        r_active <= 1'b1;
      else if (w_release && (w_wcnt_n == '0) && !w_full_n[~r_rd_bank])
        r_active <= 1'b0;
      if (r_state == S_ARM)
        r_rcnt <= '0;
      else if (w_store_acc)
        r_rcnt <= r_rcnt + ONE_RT;
      if (w_store_acc) begin
        ODST_wb  <= w_rd_row[ROW_W-1:DATA_W];
        WData_wb <= w_rd_row[DATA_W-1:0];
      end
    end
  end

  assign BUSY = r_active || (|r_full) || (r_state != S_IDLE);

endmodule

// File: tb/tb_acc_wbuf_pingpong.sv
// Directed bench for acc_wbuf_pingpong with a write-back scoreboard.
module tb_acc_wbuf_pingpong;

  logic        CLK, RSTN, CLR_DP, ACC_ctrl, OMWrite_om, WB_READY;
  logic [2:0]  ROW_TOTAL;
  logic [3:0]  ODST_om;
  logic [63:0] DACC;
  logic        LOAD_DONE, STORE_DONE, EN_wb, OVF, BUSY;
  logic [3:0]  ODST_wb;
  logic [63:0] WData_wb;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_ld = 0, cnt_sd = 0, cnt_en = 0, cnt_ovf = 0;
  int ld0, sd0, en0, ovf0;
  logic [67:0] sb [$];
  logic [67:0] exp_row;
  bit   rdy_pat [7] = '{1, 0, 0, 1, 0, 1, 1};
  logic [67:0] prev_out;
  logic [2:0]  rt_val;

  acc_wbuf_pingpong #(.DATA_W(64), .ADDR_W(4), .DEPTH(4)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .CLR_DP     (CLR_DP),
    .ACC_ctrl   (ACC_ctrl),
    .ROW_TOTAL  (ROW_TOTAL),
    .ODST_om    (ODST_om),
    .OMWrite_om (OMWrite_om),
    .DACC       (DACC),
    .WB_READY   (WB_READY),
    .LOAD_DONE  (LOAD_DONE),
    .STORE_DONE (STORE_DONE),
    .ODST_wb    (ODST_wb),
    .EN_wb      (EN_wb),
    .WData_wb   (WData_wb),
    .OVF        (OVF),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pulse counters and in-order write-back checking.
  always @(negedge CLK) begin
    if (LOAD_DONE === 1'b1) cnt_ld++;
    if (OVF === 1'b1) cnt_ovf++;
    if (STORE_DONE === 1'b1) begin
      cnt_sd++;
      check("store_done_with_en", 128'(EN_wb), 128'(1));
    end
    if (EN_wb === 1'b1) begin
      cnt_en++;
      if (sb.size() == 0) begin
        check("write_with_empty_sb", 128'(EN_wb), 128'(0));
      end else begin
        exp_row = sb.pop_front();
        check("wb_row", 128'({ODST_wb, WData_wb}), 128'(exp_row));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic snap();
    ld0 = cnt_ld; sd0 = cnt_sd; en0 = cnt_en; ovf0 = cnt_ovf;
  endtask

  task automatic start_tile(input logic [2:0] rt);
    ACC_ctrl = 1'b1; ROW_TOTAL = rt;
    tick();
    ACC_ctrl = 1'b0;
  endtask

  task automatic send_row(input logic [3:0] addr, input bit expect_drain);
    logic [63:0] d;
    d = {$urandom, $urandom};
    OMWrite_om = 1'b1; ODST_om = addr; DACC = d;
    if (expect_drain) sb.push_back({addr, d});
    tick();
    OMWrite_om = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 128'(BUSY), 128'(0));
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({LOAD_DONE, STORE_DONE, ODST_wb, EN_wb, WData_wb, OVF, BUSY});
  endfunction

  initial begin
    RSTN = 1'b0; CLR_DP = 1'b0; ACC_ctrl = 1'b0; ROW_TOTAL = '0;
    ODST_om = '0; OMWrite_om = 1'b0; DACC = '0; WB_READY = 1'b1;
    tick(); tick();
    check("reset_outputs", all_outs(), 128'(0));
    RSTN = 1'b1;
    tick();

    // Single tile of four rows, free-flowing memory
    snap();
    start_tile(3'd4);
    send_row(4'd3, 1'b1);
    send_row(4'd1, 1'b1);
    send_row(4'd0, 1'b1);
    check("t1_no_load_early", 128'(LOAD_DONE), 128'(0));
    send_row(4'd2, 1'b1);
    check("t1_load_done", 128'(LOAD_DONE), 128'(1));
    tick(); tick();
    check("t1_en_not_yet", 128'(EN_wb), 128'(0));
    tick();
    check("t1_first_en", 128'({EN_wb, ODST_wb}), 128'({1'b1, 4'd3}));
    wait_idle("t1");
    tick();
    check("t1_ld_cnt", 128'(cnt_ld - ld0), 128'(1));
    check("t1_sd_cnt", 128'(cnt_sd - sd0), 128'(1));
    check("t1_en_cnt", 128'(cnt_en - en0), 128'(4));

    // Three-row tiles: bank1 fills while bank0 drains, two rows left over
    snap();
    start_tile(3'd3);
    for (int i = 0; i < 6; i++) send_row(4'(i + 8), 1'b1);
    repeat (4) tick();
    send_row(4'd14, 1'b0);
    send_row(4'd15, 1'b0);
    repeat (6) tick();
    check("t2_ld_cnt", 128'(cnt_ld - ld0), 128'(2));
    check("t2_sd_cnt", 128'(cnt_sd - sd0), 128'(2));
    check("t2_en_cnt", 128'(cnt_en - en0), 128'(6));
    check("t2_no_ovf", 128'(cnt_ovf - ovf0), 128'(0));
    check("t2_busy", 128'(BUSY), 128'(1));
    check("t2_sb_empty", 128'(sb.size()), 128'(0));
    CLR_DP = 1'b1;
    tick();
    CLR_DP = 1'b0;
    check("t2_clr_outputs", all_outs(), 128'(0));
    tick();

    // Back-pressure pattern during a drain
    snap();
    WB_READY = 1'b0;
    start_tile(3'd4);
    for (int i = 0; i < 4; i++) send_row(4'(5 - i), 1'b1);
    tick(); tick();
    prev_out = '0;
    for (int i = 0; i < 7; i++) begin
      WB_READY = rdy_pat[i];
      tick();
      check("t3_en_follows_ready", 128'(EN_wb), 128'(rdy_pat[i]));
      if (!rdy_pat[i]) check("t3_stall_hold", 128'({ODST_wb, WData_wb}), 128'(prev_out));
      prev_out = {ODST_wb, WData_wb};
    end
    check("t3_store_done", 128'(STORE_DONE), 128'(1));
    WB_READY = 1'b1;
    wait_idle("t3");
    tick();
    check("t3_en_cnt", 128'(cnt_en - en0), 128'(4));

    // Both banks full with memory stalled, one extra row overflows
    snap();
    WB_READY = 1'b0;
    start_tile(3'd4);
    for (int i = 0; i < 8; i++) send_row(4'(i), 1'b1);
    check("t4_second_load", 128'(LOAD_DONE), 128'(1));
    send_row(4'd9, 1'b0);
    check("t4_ovf_pulse", 128'(OVF), 128'(1));
    tick();
    check("t4_ovf_clears", 128'(OVF), 128'(0));
    WB_READY = 1'b1;
    wait_idle("t4");
    tick();
    check("t4_ld_cnt", 128'(cnt_ld - ld0), 128'(2));
    check("t4_sd_cnt", 128'(cnt_sd - sd0), 128'(2));
    check("t4_en_cnt", 128'(cnt_en - en0), 128'(8));
    check("t4_ovf_cnt", 128'(cnt_ovf - ovf0), 128'(1));
    check("t4_sb_empty", 128'(sb.size()), 128'(0));

    // Out-of-range row totals fall back to DEPTH
    for (int k = 0; k < 2; k++) begin
      snap();
      rt_val = (k == 0) ? 3'd0 : 3'd7;
      start_tile(rt_val);
      for (int i = 0; i < 3; i++) send_row(4'(i + 4 * k), 1'b1);
      check("t5_no_load_at_3", 128'(LOAD_DONE), 128'(0));
      send_row(4'd12, 1'b1);
      check("t5_load_at_4", 128'(LOAD_DONE), 128'(1));
      wait_idle("t5");
      tick();
      check("t5_en_cnt", 128'(cnt_en - en0), 128'(4));
    end

    // Datapath clear during a drain, then async reset mid-fill
    snap();
    start_tile(3'd4);
    send_row(4'd7, 1'b1);
    send_row(4'd6, 1'b1);
    send_row(4'd5, 1'b0);
    send_row(4'd4, 1'b0);
    tick(); tick(); tick();
    check("t6_first_en", 128'(EN_wb), 128'(1));
    tick();
    check("t6_second_en", 128'(EN_wb), 128'(1));
    CLR_DP = 1'b1;
    tick();
    check("t6_clr_outputs", all_outs(), 128'(0));
    CLR_DP = 1'b0;
    repeat (3) tick();
    check("t6_no_store_done", 128'(cnt_sd - sd0), 128'(0));
    check("t6_en_cnt", 128'(cnt_en - en0), 128'(2));

    start_tile(3'd4);
    send_row(4'd1, 1'b0);
    send_row(4'd2, 1'b0);
    RSTN = 1'b0;
    tick();
    check("t6_rst_outputs", all_outs(), 128'(0));
    RSTN = 1'b1;
    tick();
    snap();
    start_tile(3'd4);
    for (int i = 0; i < 4; i++) send_row(4'(i * 3), 1'b1);
    wait_idle("t6_new");
    tick();
    check("t6_new_ld", 128'(cnt_ld - ld0), 128'(1));
    check("t6_new_sd", 128'(cnt_sd - sd0), 128'(1));
    check("t6_new_en", 128'(cnt_en - en0), 128'(4));
    check("t6_sb_empty", 128'(sb.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
